// File: rtl/disp_pkg.sv
// Shared display constants, control codes and console FSM state type for the VGA text path.
// Pure declarations: no latency or flow-control behaviour of its own.
package disp_pkg;

  localparam int ASCII_SIZE = 8;
  localparam int CHARS_HORZ = 80;   // 640 px / 8 px glyphs
  localparam int CHARS_VERT = 30;   // 480 px / 16 px glyphs
  localparam int ROM_SIZE   = 4096; // 256 glyphs x 16 scanlines

  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR
  } console_state_t;

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream console writer: updates the screen buffer/cursor in 1 cycle per byte; scroll/clear take CHARS_VERT cycles.
// Backpressure: char_ready is low while scrolling or clearing; the sender must hold its byte.
module text_console_writer #(
  parameter int ASCII_SIZE = disp_pkg::ASCII_SIZE,
  parameter int CHARS_HORZ = disp_pkg::CHARS_HORZ,
  parameter int CHARS_VERT = disp_pkg::CHARS_VERT
) (
  input  logic                          clk_25M,
  input  logic                          reset,
  input  logic                          char_valid,
  input  logic [ASCII_SIZE-1:0]         char_data,
  output logic                          char_ready,
  output logic [ASCII_SIZE-1:0]         charBuffer [CHARS_VERT][CHARS_HORZ],
  output logic [$clog2(CHARS_VERT)-1:0] cur_row,
  output logic [$clog2(CHARS_HORZ)-1:0] cur_col
);

  import disp_pkg::*;

  localparam int ROW_W = $clog2(CHARS_VERT);
  localparam int COL_W = $clog2(CHARS_HORZ);

  localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(CHARS_VERT - 1);
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(CHARS_HORZ - 1);
  localparam logic [ASCII_SIZE-1:0] SPACE    = ASCII_SIZE'(CH_SPACE);
  localparam logic [ASCII_SIZE-1:0] CODE_LF  = ASCII_SIZE'(CH_LF);
  localparam logic [ASCII_SIZE-1:0] CODE_CR  = ASCII_SIZE'(CH_CR);
  localparam logic [ASCII_SIZE-1:0] CODE_BS  = ASCII_SIZE'(CH_BS);
  localparam logic [ASCII_SIZE-1:0] CODE_FF  = ASCII_SIZE'(CH_FF);
  localparam logic [ASCII_SIZE-1:0] PRINT_LO = ASCII_SIZE'(CH_PRINT_LO);
  localparam logic [ASCII_SIZE-1:0] PRINT_HI = ASCII_SIZE'(CH_PRINT_HI);

  console_state_t        state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      r_q, r_d;

  logic                  wr_en;
  logic [ROW_W-1:0]      wr_row;
  logic [COL_W-1:0]      wr_col;
  logic [ASCII_SIZE-1:0] wr_dat;
  logic                  row_adv;
  logic                  printable;

  logic [ASCII_SIZE-1:0] screen [CHARS_VERT][CHARS_HORZ];

  assign printable  = (char_data >= PRINT_LO) && (char_data <= PRINT_HI);
  assign char_ready = (state_q == IDLE);
  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign charBuffer = screen;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    r_d     = r_q;
    wr_en   = 1'b0;
    wr_row  = row_q;
    wr_col  = col_q;
    wr_dat  = char_data;
    row_adv = 1'b0;

    case (state_q)
      IDLE: begin
        if (char_valid) begin
          if (printable) begin
            wr_en = 1'b1;
            if (col_q == LAST_COL) begin
              col_d   = '0;
              row_adv = 1'b1;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (char_data == CODE_LF) begin
            col_d   = '0;
            row_adv = 1'b1;
          end else if (char_data == CODE_CR) begin
            col_d = '0;
          end else if (char_data == CODE_BS) begin
            // No reverse line wrap: backspace at column 0 does nothing.
            if (col_q != '0) begin
              col_d  = col_q - COL_W'(1);
              wr_en  = 1'b1;
              wr_col = col_q - COL_W'(1);
              wr_dat = SPACE;
            end
          end else if (char_data == CODE_FF) begin
            state_d = CLEAR;
            r_d     = '0;
          end

          if (row_adv) begin
            if (row_q < LAST_ROW) begin
              row_d = row_q + ROW_W'(1);
            end else begin
              state_d = SCROLL;
              r_d     = '0;
            end
          end
        end
      end

      SCROLL: begin
        if (r_q == LAST_ROW) begin
          state_d = IDLE;
          r_d     = '0;
        end else begin
          r_d = r_q + ROW_W'(1);
        end
      end

      CLEAR: begin
        if (r_q == LAST_ROW) begin
          state_d = IDLE;
          r_d     = '0;
          row_d   = '0;
          col_d   = '0;
        end else begin
          r_d = r_q + ROW_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        r_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      r_q     <= r_d;
    end
  end

  // One register per cell; during SCROLL row r takes row r+1, and the last row takes blanks.
  for (genvar gr = 0; gr < CHARS_VERT; gr++) begin : g_row
    for (genvar gc = 0; gc < CHARS_HORZ; gc++) begin : g_col
      logic [ASCII_SIZE-1:0] cell_q;
      logic [ASCII_SIZE-1:0] below;

      if (gr < CHARS_VERT - 1) begin : g_src
        assign below = screen[gr+1][gc];
      end else begin : g_blank
        assign below = SPACE;
      end

      always_ff @(posedge clk_25M) begin
        if (reset) begin
          cell_q <= SPACE;
        end else if (wr_en && (wr_row == ROW_W'(gr)) && (wr_col == COL_W'(gc))) begin
          cell_q <= wr_dat;
        end else if (r_q == ROW_W'(gr)) begin
          if (state_q == SCROLL) begin
            cell_q <= below;
          end else if (state_q == CLEAR) begin
            cell_q <= SPACE;
          end
        end
      end

      assign screen[gr][gc] = cell_q;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset, writes, control codes, wrap, scroll, clear, reset mid-scroll.
// Inputs driven and outputs sampled on the falling edge; expected screen kept in a bench-side array.
module tb_text_console_writer;

  localparam int AW = 8;
  localparam int H  = 80;
  localparam int V  = 30;

  logic          clk_25M = 1'b0;
  logic          reset = 1'b1;
  logic          char_valid = 1'b0;
  logic [AW-1:0] char_data = '0;
  logic          char_ready;
  logic [AW-1:0] cb [V][H];
  logic [4:0]    cur_row;
  logic [6:0]    cur_col;

  logic [7:0]    exp_buf [V][H];
  int            diff_r, diff_c;
  int            checks = 0;
  int            errors = 0;

  always #20 clk_25M = ~clk_25M;

  text_console_writer #(
    .ASCII_SIZE(AW),
    .CHARS_HORZ(H),
    .CHARS_VERT(V)
  ) dut (
    .clk_25M   (clk_25M),
    .reset     (reset),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .charBuffer(cb),
    .cur_row   (cur_row),
    .cur_col   (cur_col)
  );

  task automatic step();
    @(posedge clk_25M);
    @(negedge clk_25M);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    while (!char_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_wait: char_ready=%0b required 1 within 200 cycles", char_ready);
    end
    char_valid = 1'b1;
    char_data  = b;
    step();
    char_valid = 1'b0;
  endtask

  task automatic ready_low_cycles(output int n);
    n = 0;
    while (!char_ready && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        exp_buf[r][c] = 8'h20;
  endtask

  task automatic scan_diff(output int n);
    n = 0;
    diff_r = 0;
    diff_c = 0;
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        if (cb[r][c] !== exp_buf[r][c]) begin
          if (n == 0) begin
            diff_r = r;
            diff_c = c;
          end
          n++;
        end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int r, input int c);
    return 8'(32'h21 + ((r * 3 + c) % 90));
  endfunction

  task automatic test_reset();
    int nd;
    reset_dut();
    clear_exp();
    checks++;
    if (char_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %0b required 1", char_ready);
    end
    scan_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL reset_buffer: %0d cells differ, first [%0d][%0d] got %02h required %02h",
               nd, diff_r, diff_c, cb[diff_r][diff_c], exp_buf[diff_r][diff_c]);
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 7'd0}) begin
      errors++;
      $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_basic_write();
    int drops;
    drops = 0;
    for (int i = 0; i < 2; i++) begin
      if (char_ready !== 1'b1) drops++;
      send(i == 0 ? 8'h48 : 8'h69);
    end
    if (char_ready !== 1'b1) drops++;
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL basic_ready: char_ready low on %0d samples required 0", drops);
    end
    checks++;
    if (cb[0][0] !== 8'h48 || cb[0][1] !== 8'h69) begin
      errors++;
      $display("FAIL basic_cells: got %02h %02h required 48 69", cb[0][0], cb[0][1]);
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 7'd2}) begin
      errors++;
      $display("FAIL basic_cursor: got (%0d,%0d) required (0,2)", cur_row, cur_col);
    end
  endtask

  task automatic test_ctrl_codes();
    int nd;
    send(8'h01);
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 7'd2} || cb[0][1] !== 8'h69) begin
      errors++;
      $display("FAIL ignored_byte: cursor (%0d,%0d) cell %02h required (0,2) 69", cur_row, cur_col, cb[0][1]);
    end
    send(8'h08);
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 7'd1} || cb[0][1] !== 8'h20 || cb[0][0] !== 8'h48) begin
      errors++;
      $display("FAIL backspace: cursor (%0d,%0d) cells %02h %02h required (0,1) 48 20",
               cur_row, cur_col, cb[0][0], cb[0][1]);
    end
    send(8'h0D);
    checks++;
    if ({cur_row, cur_col} !== {5'd0, 7'd0}) begin
      errors++;
      $display("FAIL carriage_return: got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    send(8'h0A);
    checks++;
    if ({cur_row, cur_col} !== {5'd1, 7'd0}) begin
      errors++;
      $display("FAIL line_feed: got (%0d,%0d) required (1,0)", cur_row, cur_col);
    end
    clear_exp();
    exp_buf[0][0] = 8'h48;
    scan_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL ctrl_buffer: %0d cells differ, first [%0d][%0d] got %02h required %02h",
               nd, diff_r, diff_c, cb[diff_r][diff_c], exp_buf[diff_r][diff_c]);
    end
  endtask

  task automatic test_line_wrap();
    int nd;
    reset_dut();
    for (int i = 0; i < H; i++) send(8'h41);
    send(8'h42);
    clear_exp();
    for (int c = 0; c < H; c++) exp_buf[0][c] = 8'h41;
    exp_buf[1][0] = 8'h42;
    scan_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL wrap_buffer: %0d cells differ, first [%0d][%0d] got %02h required %02h",
               nd, diff_r, diff_c, cb[diff_r][diff_c], exp_buf[diff_r][diff_c]);
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd1, 7'd1}) begin
      errors++;
      $display("FAIL wrap_cursor: got (%0d,%0d) required (1,1)", cur_row, cur_col);
    end
  endtask

  task automatic test_scroll();
    int nd, low;
    reset_dut();
    for (int r = 0; r < V - 1; r++)
      for (int c = 0; c < H; c++)
        send(pat(r, c));
    for (int c = 0; c < 5; c++) send(pat(V - 1, c));
    checks++;
    if ({cur_row, cur_col} !== {5'd29, 7'd5}) begin
      errors++;
      $display("FAIL scroll_precursor: got (%0d,%0d) required (29,5)", cur_row, cur_col);
    end
    send(8'h0A);
    ready_low_cycles(low);
    checks++;
    if (low !== 30) begin
      errors++;
      $display("FAIL scroll_busy: char_ready low %0d cycles required 30", low);
    end
    clear_exp();
    for (int r = 0; r < V - 2; r++)
      for (int c = 0; c < H; c++)
        exp_buf[r][c] = pat(r + 1, c);
    for (int c = 0; c < 5; c++) exp_buf[V-2][c] = pat(V - 1, c);
    scan_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL scroll_buffer: %0d cells differ, first [%0d][%0d] got %02h required %02h",
               nd, diff_r, diff_c, cb[diff_r][diff_c], exp_buf[diff_r][diff_c]);
    end
    checks++;
    if ({cur_row, cur_col} !== {5'd29, 7'd0}) begin
      errors++;
      $display("FAIL scroll_cursor: got (%0d,%0d) required (29,0)", cur_row, cur_col);
    end
  endtask

  task automatic test_last_cell();
    int nd, low;
    reset_dut();
    for (int i = 0; i < V - 1; i++) send(8'h0A);
    for (int c = 0; c < H - 1; c++) send(8'h61);
    checks++;
    if ({cur_row, cur_col} !== {5'd29, 7'd79}) begin
      errors++;
      $display("FAIL last_cell_precursor: got (%0d,%0d) required (29,79)", cur_row, cur_col);
    end
    send(8'h5A);
    ready_low_cycles(low);
    checks++;
    if (low !== 30) begin
      errors++;
      $display("FAIL last_cell_busy: char_ready low %0d cycles required 30", low);
    end
    clear_exp();
    for (int c = 0; c < H - 1; c++) exp_buf[V-2][c] = 8'h61;
    exp_buf[V-2][H-1] = 8'h5A;
    scan_diff(nd);
    checks++;
    if (nd !== 0 || {cur_row, cur_col} !== {5'd29, 7'd0}) begin
      errors++;
      $display("FAIL last_cell: %0d cells differ (first [%0d][%0d]) cursor (%0d,%0d) required 0 cells, (29,0)",
               nd, diff_r, diff_c, cur_row, cur_col);
    end
  endtask

  task automatic test_clear_backspace();
    int nd, low;
    reset_dut();
    for (int i = 0; i < 5; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h78);
    checks++;
    if ({cur_row, cur_col} !== {5'd5, 7'd10}) begin
      errors++;
      $display("FAIL clear_precursor: got (%0d,%0d) required (5,10)", cur_row, cur_col);
    end
    send(8'h0C);
    ready_low_cycles(low);
    checks++;
    if (low !== 30) begin
      errors++;
      $display("FAIL clear_busy: char_ready low %0d cycles required 30", low);
    end
    clear_exp();
    scan_diff(nd);
    checks++;
    if (nd !== 0 || {cur_row, cur_col} !== {5'd0, 7'd0}) begin
      errors++;
      $display("FAIL clear_result: %0d cells differ (first [%0d][%0d]) cursor (%0d,%0d) required 0 cells, (0,0)",
               nd, diff_r, diff_c, cur_row, cur_col);
    end
    send(8'h08);
    scan_diff(nd);
    checks++;
    if (nd !== 0 || {cur_row, cur_col} !== {5'd0, 7'd0} || char_ready !== 1'b1) begin
      errors++;
      $display("FAIL bs_col0: %0d cells differ cursor (%0d,%0d) ready %0b required 0 cells, (0,0), 1",
               nd, cur_row, cur_col, char_ready);
    end
  endtask

  task automatic test_reset_mid_scroll();
    int nd;
    reset_dut();
    send(8'h51);
    for (int i = 0; i < V - 1; i++) send(8'h0A);
    send(8'h52);
    send(8'h0A);
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (char_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_scroll_busy: char_ready got %0b required 0", char_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_exp();
    scan_diff(nd);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL mid_scroll_buffer: %0d cells differ, first [%0d][%0d] got %02h required 20",
               nd, diff_r, diff_c, cb[diff_r][diff_c]);
    end
    checks++;
    if (char_ready !== 1'b1 || {cur_row, cur_col} !== {5'd0, 7'd0}) begin
      errors++;
      $display("FAIL mid_scroll_state: ready %0b cursor (%0d,%0d) required 1, (0,0)",
               char_ready, cur_row, cur_col);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_ctrl_codes();
    test_line_wrap();
    test_scroll();
    test_last_cell();
    test_clear_backspace();
    test_reset_mid_scroll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
